cpu_bus_cycle_generator: RTL

- 8088 maximum-mode bus-cycle initiator: the encoder side of the status protocol that the bus controller and arbiter decode.
- Takes one transaction request at a time from a core/sequencer.
- Drives processor_status, address, write data and lock with T1-T4/TW timing.
- Honours wait states via ready, and bus release via address_enable_n.
- Returns read data on a single-cycle response strobe.

---
 rtl/cpu_bus_pkg.sv | 34 +++
 rtl/bus_wait_timer.sv | 27 ++
 rtl/cpu_bus_cycle_generator.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared status codes, bus states and type helpers for the 8088 bus-cycle initiator
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_INTA       = 3'b000,
    ST_IO_READ    = 3'b001,
    ST_IO_WRITE   = 3'b010,
    ST_HALT       = 3'b011,
    ST_CODE_FETCH = 3'b100,
    ST_MEM_READ   = 3'b101,
    ST_MEM_WRITE  = 3'b110,
    ST_PASSIVE    = 3'b111
  } status_e;

  typedef enum logic [2:0] {
    BUS_IDLE = 3'd0,
    BUS_T1   = 3'd1,
    BUS_T2   = 3'd2,
    BUS_T3   = 3'd3,
    BUS_TW   = 3'd4,
    BUS_T4   = 3'd5
  } bus_state_e;

  localparam logic [2:0] STATUS_PASSIVE = ST_PASSIVE;

  function automatic logic is_read_type(input logic [2:0] t);
    return (t == ST_INTA) || (t == ST_IO_READ) || (t == ST_CODE_FETCH) || (t == ST_MEM_READ);
  endfunction

  function automatic logic is_write_type(input logic [2:0] t);
    return (t == ST_IO_WRITE) || (t == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - consecutive wait-state counter raising a timeout on the WAIT_TIMEOUT-th TW clock
module bus_wait_timer #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam int CW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  // r_count holds the number of TW clocks already completed before the current one
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_timeout) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_timeout = (WAIT_TIMEOUT != 0) && i_enable && (r_count == CW'(WAIT_TIMEOUT - 1));

endmodule

// File: rtl/cpu_bus_cycle_generator.sv
// rtl/cpu_bus_cycle_generator.sv - 8088 max-mode bus-cycle initiator; CPU_BUS_INTA_PAIR_EN enables paired INTA cycles
module cpu_bus_cycle_generator
  import cpu_bus_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_type,
  input  logic        req_lock,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_write_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_error,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  input  logic [7:0]  internal_data_bus,
  input  logic        ready,
  input  logic        address_enable_n
);

  localparam logic [2:0] S_IDLE = BUS_IDLE;
  localparam logic [2:0] S_T1   = BUS_T1;
  localparam logic [2:0] S_T2   = BUS_T2;
  localparam logic [2:0] S_T3   = BUS_T3;
  localparam logic [2:0] S_TW   = BUS_TW;
  localparam logic [2:0] S_T4   = BUS_T4;

  logic [2:0]  r_state;
  logic [2:0]  r_type;
  logic [19:0] r_address;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_lock_n;
  logic        r_error;

  logic w_accept;
  logic w_timeout;
  logic w_leave_wait;
  logic w_pair_first;
  logic w_lock_req;

  bus_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clear   (r_state != S_TW),
    .i_enable  (r_state == S_TW),
    .o_timeout (w_timeout)
  );

`ifdef CPU_BUS_INTA_PAIR_EN
  logic r_inta_second;

  // The first INTA T4 chains straight into the second cycle without a response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inta_second <= 1'b0;
    end else if (w_pair_first) begin
      r_inta_second <= 1'b1;
    end else if (w_accept) begin
      r_inta_second <= 1'b0;
    end
  end

  assign w_pair_first = (r_state == S_T4) && (r_type == ST_INTA) && !r_inta_second;
  assign w_lock_req   = req_lock || (req_type == ST_INTA);
`else
  assign w_pair_first = 1'b0;
  assign w_lock_req   = req_lock;
`endif

  assign req_ready = ((r_state == S_IDLE) || ((r_state == S_T4) && !w_pair_first))
                     && !address_enable_n && !reset;
  assign w_accept  = req_valid && req_ready;

  // Halt never samples ready; timeout only matters once in TW
  assign w_leave_wait = ((r_state == S_T3) && (ready || (r_type == ST_HALT)))
                     || ((r_state == S_TW) && (ready || w_timeout));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_type    <= STATUS_PASSIVE;
      r_address <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_lock_n  <= 1'b1;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_T4: begin
          if (w_pair_first) begin
            r_state <= S_T1;
          end else if (w_accept) begin
            r_state   <= (req_type == ST_PASSIVE) ? S_T4 : S_T1;
            r_type    <= req_type;
            r_address <= req_address;
            r_wdata   <= req_write_data;
            r_rdata   <= '0;
            r_error   <= (req_type == ST_PASSIVE);
            r_lock_n  <= !(w_lock_req && (req_type != ST_PASSIVE));
          end else begin
            r_state  <= S_IDLE;
            r_lock_n <= 1'b1;
          end
        end
        S_T1: r_state <= S_T2;
        S_T2: r_state <= S_T3;
        S_T3, S_TW: begin
          if (w_leave_wait) begin
            r_state <= S_T4;
          end else begin
            r_state <= S_TW;
          end
          if (w_leave_wait && is_read_type(r_type)) begin
            r_rdata <= internal_data_bus;
          end
          if ((r_state == S_TW) && w_timeout && !ready) begin
            r_error <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    processor_status = STATUS_PASSIVE;
    if ((r_state == S_T1) || (r_state == S_T2) || (r_state == S_T3) || (r_state == S_TW)) begin
      processor_status = r_type;
    end
  end

  always_comb begin
    cpu_data_bus = '0;
    if (is_write_type(r_type) && ((r_state == S_T2) || (r_state == S_T3)
                                  || (r_state == S_TW) || (r_state == S_T4))) begin
      cpu_data_bus = r_wdata;
    end
  end

  assign resp_valid       = (r_state == S_T4) && !w_pair_first;
  assign resp_data        = r_rdata;
  assign resp_error       = r_error;
  assign processor_lock_n = r_lock_n;
  assign cpu_address      = r_address;

endmodule
